// File: rtl/keypad_fifo_drain_display.sv
// Drains 4-bit key codes from the keypad FIFO and shows the last two on a multiplexed
// two-digit seven-segment display. Optional `clear` input is enabled by KEYPAD_DRAIN_CLEAR_EN.
module keypad_fifo_drain_display #(
  parameter int WIDTH         = 4,   // must stay 4: one hex digit per code
  parameter int HOLD_CYCLES   = 32,
  parameter int REFRESH_COUNT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_in,
`ifdef KEYPAD_DRAIN_CLEAR_EN
  input  logic             clear,
`endif
  output logic             read,
  output logic [6:0]       Cathode,
  output logic             Left_anode,
  output logic             Right_anode,
  output logic [1:0]       digit_valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, HOLD} state_t;

  localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_COUNT - 1);

  state_t           state;
  state_t           state_next;
  logic [15:0]      hold_cnt;
  logic [15:0]      refresh_cnt;
  logic             sel;
  logic [WIDTH-1:0] left_digit;
  logic [WIDTH-1:0] right_digit;
  logic [WIDTH-1:0] shown_digit;
  logic             shown_valid;

  // Active-high abcdefg pattern for one hex digit.
  function automatic logic [6:0] seg(input logic [3:0] code);
    case (code)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      default: seg = 7'h47;
    endcase
  endfunction

  // NOTE: next state is defaulted to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = POP;
      POP:     state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (hold_cnt == 16'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      read  <= 1'b0;
    end else begin
      state <= state_next;
      // Registered pop: high exactly for the cycle spent in POP.
      read  <= (state == IDLE) && !empty;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= 16'd0;
    end else if (state == CAPTURE) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == HOLD && hold_cnt != 16'd0) begin
      hold_cnt <= hold_cnt - 16'd1;
    end
  end

  // NOTE: the digit registers are reset along with everything else so the display starts blank.
  always_ff @(posedge clock) begin
    if (reset) begin
      left_digit  <= '0;
      right_digit <= '0;
      digit_valid <= 2'b00;
    end else if (state == CAPTURE) begin
`ifdef KEYPAD_DRAIN_CLEAR_EN
      if (clear) begin
        // Clear wipes the older digit, the fresh capture still lands on the right.
        left_digit  <= '0;
        right_digit <= data_in;
        digit_valid <= 2'b01;
      end else begin
        left_digit  <= right_digit;
        right_digit <= data_in;
        digit_valid <= {digit_valid[0], 1'b1};
      end
`else
      left_digit  <= right_digit;
      right_digit <= data_in;
      digit_valid <= {digit_valid[0], 1'b1};
`endif
    end
`ifdef KEYPAD_DRAIN_CLEAR_EN
    else if (clear) begin
      left_digit  <= '0;
      right_digit <= '0;
      digit_valid <= 2'b00;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= 16'd0;
      sel         <= 1'b0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= 16'd0;
      sel         <= ~sel;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  assign shown_digit = sel ? left_digit : right_digit;
  assign shown_valid = sel ? digit_valid[1] : digit_valid[0];

  // Pins are registered, so they trail sel and digit changes by one clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      Cathode     <= 7'h7F;
      Right_anode <= 1'b0;
      Left_anode  <= 1'b1;
    end else begin
      Cathode     <= shown_valid ? ~seg(shown_digit) : 7'h7F;
      Right_anode <= sel;
      Left_anode  <= ~sel;
    end
  end

endmodule

// File: tb/tb_keypad_fifo_drain_display.sv
// Directed bench for keypad_fifo_drain_display with a small FIFO model feeding data_in.
// Define KEYPAD_DRAIN_CLEAR_EN to also exercise the clear input.
module tb_keypad_fifo_drain_display;

  logic       clock = 1'b0;
  logic       reset;
  logic       empty;
  logic [3:0] data_in;
`ifdef KEYPAD_DRAIN_CLEAR_EN
  logic       clear;
`endif
  logic       read;
  logic [6:0] Cathode;
  logic       Left_anode;
  logic       Right_anode;
  logic [1:0] digit_valid;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  int         cycle_no = 0;
  logic [3:0] fifo_q[$];
  int         read_log[$];
  bit         pop_pending = 1'b0;

  keypad_fifo_drain_display #(
    .WIDTH(4), .HOLD_CYCLES(32), .REFRESH_COUNT(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .empty       (empty),
    .data_in     (data_in),
`ifdef KEYPAD_DRAIN_CLEAR_EN
    .clear       (clear),
`endif
    .read        (read),
    .Cathode     (Cathode),
    .Left_anode  (Left_anode),
    .Right_anode (Right_anode),
    .digit_valid (digit_valid),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: the FIFO pops on the edge after a read, then outputs are sampled at negedge.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (pop_pending) begin
      if (fifo_q.size() == 0) check("read_when_empty", 1, 0);
      else data_in = fifo_q.pop_front();
      empty = (fifo_q.size() == 0);
    end
    @(negedge clock);
    cycle_no++;
    pop_pending = read;
    if (read) read_log.push_back(cycle_no);
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    empty = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin cyc(); n++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic show(input string tag, input logic [6:0] exp_l, input logic [6:0] exp_r);
    int n = 0;
    while (Right_anode !== 1'b0 && n < 20) begin cyc(); n++; end
    check({tag, "_ranode"}, Right_anode, 0);
    check({tag, "_right"}, Cathode, exp_r);
    n = 0;
    while (Left_anode !== 1'b0 && n < 20) begin cyc(); n++; end
    check({tag, "_lanode"}, Left_anode, 0);
    check({tag, "_left"}, Cathode, exp_l);
  endtask

  task automatic check_gaps(input string tag, input int count);
    check({tag, "_reads"}, read_log.size(), count);
    if (read_log.size() == count)
      for (int i = 1; i < count; i++)
        check({tag, "_gap"}, read_log[i] - read_log[i-1], 35);
  endtask

  initial begin
    reset   = 1'b1;
    empty   = 1'b1;
    data_in = 4'h0;
`ifdef KEYPAD_DRAIN_CLEAR_EN
    clear   = 1'b0;
`endif
    repeat (3) cyc();
    check("rst_read", read, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", digit_valid, 0);
    check("rst_cathode", Cathode, 7'h7F);
    check("rst_ranode", Right_anode, 0);
    check("rst_lanode", Left_anode, 1);
    reset = 1'b0;

    // Empty FIFO: blank display, anodes swap every 8 clocks starting on the right digit.
    for (int k = 1; k <= 100; k++) begin
      cyc();
      check("idle_read", read, 0);
      check("idle_cathode", Cathode, 7'h7F);
      check("idle_ranode", Right_anode, ((k - 1) / 8) % 2);
      check("idle_lanode", Left_anode, 1 - ((k - 1) / 8) % 2);
    end

    // Single code: read one cycle after empty drops, capture two edges later.
    read_log.delete();
    push(4'h5);
    cyc();
    check("pop5_read", read, 1);
    check("pop5_busy", busy, 1);
    cyc();
    check("pop5_read_once", read, 0);
    check("pop5_valid_pre", digit_valid, 2'b00);
    cyc();
    check("pop5_valid", digit_valid, 2'b01);
    wait_idle("pop5", 60);
    check("pop5_reads", read_log.size(), 1);
    show("pop5", 7'h7F, 7'h24);

    // Three codes back to back.
    read_log.delete();
    push(4'h1); push(4'hA); push(4'hF);
    repeat (130) cyc();
    check_gaps("b2b", 3);
    check("b2b_busy", busy, 0);
    check("b2b_valid", digit_valid, 2'b11);
    show("b2b", 7'h08, 7'h38);

    // FIFO runs dry after the second pop.
    read_log.delete();
    push(4'h3); push(4'h7);
    repeat (100) cyc();
    check_gaps("dry", 2);
    check("dry_busy", busy, 0);
    check("dry_valid", digit_valid, 2'b11);
    show("dry", 7'h06, 7'h0F);

    // Reset landing on the CAPTURE edge abandons the pop.
    push(4'h9);
    begin
      int n = 0;
      while (read !== 1'b1 && n < 10) begin cyc(); n++; end
    end
    check("rstcap_saw_read", read, 1);
    cyc();
    reset = 1'b1;
    cyc();
    check("rstcap_read", read, 0);
    check("rstcap_busy", busy, 0);
    check("rstcap_valid", digit_valid, 2'b00);
    check("rstcap_cathode", Cathode, 7'h7F);
    check("rstcap_ranode", Right_anode, 0);
    check("rstcap_lanode", Left_anode, 1);
    reset = 1'b0;
    repeat (4) cyc();

`ifdef KEYPAD_DRAIN_CLEAR_EN
    // Clear during HOLD blanks both digits; the next code shows alone on the right.
    push(4'h3); push(4'h7);
    begin
      int n = 0;
      while (digit_valid !== 2'b11 && n < 80) begin cyc(); n++; end
    end
    check("clr_loaded", digit_valid, 2'b11);
    repeat (2) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_valid", digit_valid, 2'b00);
    check("clr_busy", busy, 1);
    cyc();
    show("clr_blank", 7'h7F, 7'h7F);
    wait_idle("clr", 60);
    push(4'h2);
    repeat (5) cyc();
    wait_idle("clr2", 60);
    check("clr2_valid", digit_valid, 2'b01);
    show("clr2", 7'h7F, 7'h12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_fifo_drain_display.md
Name: keypad_fifo_drain_display

Overview:
- Reader end of the keypad FIFO. It pops 4-bit key codes from the FIFO using the FIFO's `empty`/`read` handshake.
- It shifts each popped code into a two-digit register (left = older, right = newest).
- It drives a time-multiplexed two-digit seven-segment display.
- It sits between the FIFO read port and the board display pins, replacing the bench-driven `read` pulse.

Parameters:
- WIDTH, 4, key code width; must be 4 for hex display.
- HOLD_CYCLES, 32, minimum clocks between the capture of one code and the next `read` pulse (range 1..65535).
- REFRESH_COUNT, 8, clocks each digit is lit before the anode select toggles (range 2..65535).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- empty  in  1  FIFO empty flag.
- data_in  in  WIDTH  FIFO output; valid in the cycle after `read` was high.
- read  out  1  one-cycle FIFO pop pulse, registered.
- Cathode  out  7  segments {a,b,c,d,e,f,g} = Cathode[6:0], active-low.
- Left_anode  out  1  left digit enable, active-low.
- Right_anode  out  1  right digit enable, active-low.
- digit_valid  out  2  [1]=left loaded, [0]=right loaded.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - Clock is `clock`; reset is `reset`, synchronous and active-high.
  - All state updates occur on the rising edge of `clock`.
- Reset values:
  - `read`=0, state=IDLE, hold counter=0 (hold satisfied), left/right digit regs=0.
  - `digit_valid`=2'b00, refresh counter=0, sel=0, `Right_anode`=0, `Left_anode`=1.
  - `Cathode`=7'h7F (blank), `busy`=0.
- Reset asserted in any state returns everything to these values on the next edge. A pop in flight is abandoned; the FIFO has already advanced and that code is lost by design.
- FSM states: IDLE, POP, CAPTURE, HOLD.
- IDLE:
  - If `empty`==0, go to POP; otherwise stay.
  - `empty` is sampled only in IDLE.
- POP:
  - `read`=1 for exactly this one cycle.
  - Always go to CAPTURE.
- CAPTURE:
  - On this edge: left <= right, right <= `data_in`, `digit_valid` <= {`digit_valid`[0], 1}.
  - Load the hold counter with HOLD_CYCLES-1.
  - Go to HOLD.
- HOLD:
  - Decrement the counter each cycle.
  - When the counter==0, go to IDLE.
- Latency: with `empty` falling before edge n (seen in IDLE at edge n):
  - `read` is high in cycle n..n+1.
  - `data_in` is captured at edge n+2.
  - New digits are visible from cycle n+2 onward.
- Back-to-back codes:
  - With a non-empty FIFO, `read` pulses are spaced exactly HOLD_CYCLES+3 clocks apart.
  - `read` is never high in two consecutive cycles.
- `empty` rising while in POP/CAPTURE/HOLD is ignored. `read` is only issued after `empty`==0 was sampled in IDLE, so the FIFO is never read when empty.
- Display refresh:
  - The refresh counter counts 0..REFRESH_COUNT-1 and wraps.
  - At wrap, sel toggles.
  - sel=0: `Right_anode`=0, `Left_anode`=1, `Cathode`=seg(right).
  - sel=1: `Left_anode`=0, `Right_anode`=1, `Cathode`=seg(left).
  - Exactly one anode is low in every cycle after reset.
  - Refresh runs independently of the FSM.
- Blanking: if the selected digit's `digit_valid` bit is 0, `Cathode`=7'h7F.
- seg() encoding (active-high abcdefg, then inverted onto `Cathode`):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Output registration: `Cathode` and the anodes are registered; they update one clock after sel/digit changes.

Optional Feature:
- Macro: `KEYPAD_DRAIN_CLEAR_EN`.
- When defined:
  - Adds input port `clear` (1 bit, after `data_in`).
  - `clear`=1 in any state except CAPTURE sets `digit_valid`=2'b00 and digit regs=0 on the next edge, blanking both digits.
  - The FSM and `read` are unaffected.
  - `clear` coincident with CAPTURE: capture wins for the right digit (`digit_valid`=2'b01, left=0).
- When undefined: no `clear` port; digits are blanked only by `reset`.

Test Plan:
- Reset, hold `empty`=1 for 100 cycles -> `read` never 1, `Cathode`=7'h7F in every cycle, anodes alternate every 8 cycles starting with `Right_anode`=0.
- Preload FIFO with 4'h5, `empty`=0 sampled at edge n -> `read`=1 for exactly one cycle; right digit shows seg(5), with `Cathode`=7'h24 while `Right_anode`=0; left stays blank; `digit_valid`=2'b01.
- Preload 4'h1, 4'hA, 4'hF with `empty` held low -> `read` pulses exactly 35 clocks apart (HOLD_CYCLES=32); final left=A (`Cathode` 7'h08), right=F (`Cathode` 7'h38); `digit_valid`=2'b11.
- FIFO goes empty right after the second pop -> no third `read`; FSM settles in IDLE with `busy`=0; display holds last two codes.
- Assert `reset` for one cycle during CAPTURE -> next edge: `read`=0, `busy`=0, `digit_valid`=2'b00, `Cathode`=7'h7F, `Right_anode`=0.
- With `KEYPAD_DRAIN_CLEAR_EN`: digits 3,7 loaded, pulse `clear` in HOLD -> both digits blank next edge; the next pop of 4'h2 shows right=seg(2) (`Cathode` 7'h12) with left still blank.
